cpu_top: RTL and testbench

CPU_TOP -- requirements
Module: cpu_top

---
 rtl/cpu_top.sv | 202 ++++++++++++++++++++
 tb/tb_cpu_top.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cpu_top.sv
// Single-cycle 32-bit MIPS-subset CPU whose fixed ROM bubble-sorts data words 0..N_ELEM-1, then halts.
// Optional macro DESCENDING_SORT_EN: swaps the slt operands in the ROM so the sort is descending.

module cpu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] RegData [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) RegData[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            RegData[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : RegData[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : RegData[i_ra2];
endmodule

module cpu_dmem #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    // Deliberately not reset so a bench can preload contents around reset.
    logic [31:0] memory_data [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) memory_data[i_addr] <= i_wdata;
    end

    assign o_rdata = memory_data[i_addr];
endmodule

module cpu_top #(
    parameter int N_ELEM     = 5,
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        done,
    output logic [31:0] pc_dbg
);
    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW = $clog2(DMEM_DEPTH);
    localparam logic [31:0] HALT_INSTR = {6'h04, 5'd0, 5'd0, 16'hFFFF};
    localparam logic [15:0] END_IMM    = 16'((N_ELEM - 1) * 4);
`ifdef DESCENDING_SORT_EN
    localparam logic [4:0] SLT_RS = 5'd3;
    localparam logic [4:0] SLT_RT = 5'd4;
`else
    localparam logic [4:0] SLT_RS = 5'd4;
    localparam logic [4:0] SLT_RT = 5'd3;
`endif

    // $1 = end byte offset of the shrinking pass, $2 = j*4, $3/$4 = a[j]/a[j+1], $5 = swap flag.
    function automatic logic [31:0] prog_word(input int k);
        case (k)
            0:       prog_word = {6'h08, 5'd0, 5'd1, END_IMM};
            1:       prog_word = {6'h04, 5'd1, 5'd0, 16'd11};
            2:       prog_word = {6'h08, 5'd0, 5'd2, 16'd0};
            3:       prog_word = {6'h23, 5'd2, 5'd3, 16'd0};
            4:       prog_word = {6'h23, 5'd2, 5'd4, 16'd4};
            5:       prog_word = {6'h00, SLT_RS, SLT_RT, 5'd5, 5'd0, 6'h2A};
            6:       prog_word = {6'h04, 5'd5, 5'd0, 16'd2};
            7:       prog_word = {6'h2B, 5'd2, 5'd4, 16'd0};
            8:       prog_word = {6'h2B, 5'd2, 5'd3, 16'd4};
            9:       prog_word = {6'h08, 5'd2, 5'd2, 16'd4};
            10:      prog_word = {6'h05, 5'd2, 5'd1, 16'hFFF8};
            11:      prog_word = {6'h08, 5'd1, 5'd1, 16'hFFFC};
            12:      prog_word = {6'h02, 26'd1};
            13:      prog_word = HALT_INSTR;
            default: prog_word = 32'd0;
        endcase
    endfunction

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    logic [31:0] r_pc;
    logic [31:0] w_rom [0:IMEM_DEPTH-1];
    logic [31:0] w_instr, w_pc_plus4, w_sext, w_rd1, w_rd2, w_alu_b, w_alu_y, w_mem_rdata, w_wd;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_wa;
    logic        w_reg_we, w_dst_rd, w_use_imm, w_mem_to_reg, w_is_sw, w_is_beq, w_is_bne, w_is_j;
    logic        w_take_branch;
    alu_op_t     w_alu_op;

    generate
        for (genvar gi = 0; gi < IMEM_DEPTH; gi++) begin : g_rom
            assign w_rom[gi] = prog_word(gi);
        end
    endgenerate

    assign w_instr    = w_rom[r_pc[IMEM_AW+1:2]];
    assign w_op       = w_instr[31:26];
    assign w_rs       = w_instr[25:21];
    assign w_rt       = w_instr[20:16];
    assign w_rd       = w_instr[15:11];
    assign w_funct    = w_instr[5:0];
    assign w_sext     = {{16{w_instr[15]}}, w_instr[15:0]};
    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_reg_we     = 1'b0;
        w_dst_rd     = 1'b0;
        w_use_imm    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_is_sw      = 1'b0;
        w_is_beq     = 1'b0;
        w_is_bne     = 1'b0;
        w_is_j       = 1'b0;
        w_alu_op     = ALU_ADD;
        case (w_op)
            6'h00: begin
                w_dst_rd = 1'b1;
                w_reg_we = 1'b1;
                case (w_funct)
                    6'h20:   w_alu_op = ALU_ADD;
                    6'h22:   w_alu_op = ALU_SUB;
                    6'h24:   w_alu_op = ALU_AND;
                    6'h25:   w_alu_op = ALU_OR;
                    6'h2A:   w_alu_op = ALU_SLT;
                    default: w_reg_we = 1'b0;
                endcase
            end
            6'h08: begin w_reg_we = 1'b1; w_use_imm = 1'b1; end
            6'h23: begin w_reg_we = 1'b1; w_use_imm = 1'b1; w_mem_to_reg = 1'b1; end
            6'h2B: begin w_is_sw = 1'b1; w_use_imm = 1'b1; end
            6'h04: w_is_beq = 1'b1;
            6'h05: w_is_bne = 1'b1;
            6'h02: w_is_j = 1'b1;
            default: ;
        endcase
    end

    assign w_alu_b = w_use_imm ? w_sext : w_rd2;

    always_comb begin
        case (w_alu_op)
            ALU_SUB: w_alu_y = w_rd1 - w_alu_b;
            ALU_AND: w_alu_y = w_rd1 & w_alu_b;
            ALU_OR:  w_alu_y = w_rd1 | w_alu_b;
            ALU_SLT: w_alu_y = {31'd0, $signed(w_rd1) < $signed(w_alu_b)};
            default: w_alu_y = w_rd1 + w_alu_b;
        endcase
    end

    assign w_wa          = w_dst_rd ? w_rd : w_rt;
    assign w_wd          = w_mem_to_reg ? w_mem_rdata : w_alu_y;
    assign w_take_branch = (w_is_beq && (w_rd1 == w_rd2)) || (w_is_bne && (w_rd1 != w_rd2));

    cpu_regfile reg1 (
        .clk    (clk),
        .rst    (rst),
        .i_ra1  (w_rs),
        .i_ra2  (w_rt),
        .i_we   (w_reg_we),
        .i_wa   (w_wa),
        .i_wd   (w_wd),
        .o_rd1  (w_rd1),
        .o_rd2  (w_rd2)
    );

    cpu_dmem #(.DEPTH(DMEM_DEPTH), .AW(DMEM_AW)) mem (
        .clk     (clk),
        .i_we    (w_is_sw && !rst),
        .i_addr  (w_alu_y[DMEM_AW+1:2]),
        .i_wdata (w_rd2),
        .o_rdata (w_mem_rdata)
    );

    // The halt instruction branches to itself, so the PC holds without a special case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= 32'd0;
        end else if (w_is_j) begin
            r_pc <= {w_pc_plus4[31:28], w_instr[25:0], 2'b00};
        end else if (w_take_branch) begin
            r_pc <= w_pc_plus4 + {w_sext[29:0], 2'b00};
        end else begin
            r_pc <= w_pc_plus4;
        end
    end

    assign done   = (w_instr == HALT_INSTR) && !rst;
    assign pc_dbg = r_pc;
endmodule

// File: tb/tb_cpu_top.sv
// Directed bench for cpu_top: preloads data memory, runs the ROM sort and checks results, reset and halt behaviour.
// Expected orders follow DESCENDING_SORT_EN when that macro is defined.

module tb_cpu_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done;
    logic [31:0] pc_dbg;
    int          n_assert = 0;
    int          n_fail   = 0;

    localparam logic [31:0] FILL    = 32'hA5A5A5A5;
    localparam logic [31:0] HALT_PC = 32'h34;

    cpu_top #(.N_ELEM(5), .IMEM_DEPTH(64), .DMEM_DEPTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .done   (done),
        .pc_dbg (pc_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input int a0, input int a1, input int a2, input int a3, input int a4);
        dut.mem.memory_data[0] = a0;
        dut.mem.memory_data[1] = a1;
        dut.mem.memory_data[2] = a2;
        dut.mem.memory_data[3] = a3;
        dut.mem.memory_data[4] = a4;
        for (int i = 5; i < 32; i++) dut.mem.memory_data[i] = FILL;
    endtask

    task automatic check_words(input string tag, input int e0, input int e1, input int e2,
                               input int e3, input int e4);
        int bad_fill = 0;
        check({tag, " w0"}, dut.mem.memory_data[0], e0);
        check({tag, " w1"}, dut.mem.memory_data[1], e1);
        check({tag, " w2"}, dut.mem.memory_data[2], e2);
        check({tag, " w3"}, dut.mem.memory_data[3], e3);
        check({tag, " w4"}, dut.mem.memory_data[4], e4);
        for (int i = 5; i < 32; i++) if (dut.mem.memory_data[i] !== FILL) bad_fill++;
        check({tag, " untouched words"}, bad_fill, 0);
    endtask

    task automatic run_to_done(input string tag);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " done within 200"}, {31'd0, done}, 32'd1);
        check({tag, " halt pc"}, pc_dbg, HALT_PC);
        $display("vector %s: done after %0d cycles, result %0d %0d %0d %0d %0d", tag, cyc,
                 $signed(dut.mem.memory_data[0]), $signed(dut.mem.memory_data[1]),
                 $signed(dut.mem.memory_data[2]), $signed(dut.mem.memory_data[3]),
                 $signed(dut.mem.memory_data[4]));
    endtask

    task automatic reset_now();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async reset pc", pc_dbg, 32'd0);
        check("async reset done", {31'd0, done}, 32'd0);
        check("reset clears r3", dut.reg1.RegData[3], 32'd0);
        check("reset clears r4", dut.reg1.RegData[4], 32'd0);
    endtask

    initial begin
        // Vector 1: basic sort, with reset-state and first-instruction latency checks.
        rst = 1'b1;
        preload(76, 4, 35, 2, 18);
        repeat (2) @(posedge clk);
        #1;
        check("reset pc", pc_dbg, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("first step pc", pc_dbg, 32'd4);
        check("first step r1", dut.reg1.RegData[1], 32'd16);
        run_to_done("v1");
`ifdef DESCENDING_SORT_EN
        check_words("v1", 76, 35, 18, 4, 2);
`else
        check_words("v1", 2, 4, 18, 35, 76);
`endif
        repeat (5) @(posedge clk);
        #1;
        check("halt pc holds", pc_dbg, HALT_PC);
        check("halt done holds", {31'd0, done}, 32'd1);
`ifdef DESCENDING_SORT_EN
        check_words("v1 after halt", 76, 35, 18, 4, 2);
`else
        check_words("v1 after halt", 2, 4, 18, 35, 76);
`endif

        // Vector 2: already sorted.
        reset_now();
        preload(1, 2, 3, 4, 5);
        @(negedge clk) rst = 1'b0;
        run_to_done("v2");
`ifdef DESCENDING_SORT_EN
        check_words("v2", 5, 4, 3, 2, 1);
`else
        check_words("v2", 1, 2, 3, 4, 5);
`endif

        // Vector 3: duplicates.
        reset_now();
        preload(5, 5, 1, 1, 3);
        @(negedge clk) rst = 1'b0;
        run_to_done("v3");
`ifdef DESCENDING_SORT_EN
        check_words("v3", 5, 5, 3, 1, 1);
`else
        check_words("v3", 1, 1, 3, 5, 5);
`endif

        // Vector 4: signed values.
        reset_now();
        preload(-1, 7, 0, -8, 3);
        @(negedge clk) rst = 1'b0;
        run_to_done("v4");
`ifdef DESCENDING_SORT_EN
        check_words("v4", 7, 3, 0, -1, -8);
`else
        check_words("v4", -8, -1, 0, 3, 7);
`endif

        // Vector 5: reset asserted mid-sort for two cycles, then the program restarts.
        reset_now();
        preload(76, 4, 35, 2, 18);
        @(negedge clk) rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid-sort not done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid-sort reset pc", pc_dbg, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("held reset pc", pc_dbg, 32'd0);
        @(negedge clk) rst = 1'b0;
        run_to_done("v5");
`ifdef DESCENDING_SORT_EN
        check_words("v5", 76, 35, 18, 4, 2);
`else
        check_words("v5", 2, 4, 18, 35, 76);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
